aeolus_io_port: RTL and testbench
=================================

# aeolus_io_port

Parametrised board I/O front-end for the Aeolus CPU, placed between the board pins and the CPU core inside the top level. It synchronises and debounces N raw switch inputs, registers a CPU-driven output port of configurable width, and generates a stretched reset for the core. It replaces direct wiring of `switches`/`cpuOut`, so the core sees clean, glitch-free inputs and a deterministic reset release.

## Interface
- `SW_WIDTH`, 8: number of switch channels.
- `OUT_WIDTH`, 4: width of CPU output port.
- `DEBOUNCE_CYCLES`, 16: consecutive stable cycles required to accept a switch change; must be >= 1.
- `RST_STRETCH`, 8: cycles `cpuRstOut` stays high after `reset` deasserts; must be >= 1.

- `boardCLK`  in  1  sole clock, rising-edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `switches`  in  SW_WIDTH  raw asynchronous switch pins.
- `swData`  out  SW_WIDTH  debounced switch value to CPU.
- `swChanged`  out  1  one-cycle pulse when `swData` changes.
- `cpuWrEn`  in  1  CPU output-port write strobe.
- `cpuWrData`  in  OUT_WIDTH  CPU output-port write data.
- `cpuOut`  out  OUT_WIDTH  registered output port to board.
- `cpuRstOut`  out  1  stretched reset to CPU core, active-high.

## Operation
- Reset values: sync flops 0, debounce counters 0, `swData`=0, `swChanged`=0, `cpuOut`=0, `cpuRstOut`=1, stretch counter 0.
- Per switch bit: 2-flop synchroniser, then independent debounce counter of width clog2(DEBOUNCE_CYCLES+1).
  - Synced bit != `swData` bit: counter increments; when counter == DEBOUNCE_CYCLES-1 and still differing, `swData` bit takes synced value, counter -> 0.
  - Synced bit == `swData` bit on any cycle: counter -> 0 (glitch rejected).
- `swChanged`: registered, high for exactly the cycle in which `swData` holds a new value; several bits updating on one edge give one pulse.
- Reset stretcher: states HOLD (`cpuRstOut`=1, counting) and RUN (`cpuRstOut`=0). Entered HOLD on `reset`; counts rising edges after `reset` low; on count == RST_STRETCH-1 -> RUN. RUN is terminal until next `reset`.
- Output port: in RUN, `cpuWrEn`=1 loads `cpuWrData` into `cpuOut` at the edge. In HOLD, `cpuWrEn` ignored, `cpuOut` holds 0.
- Debounce runs in both HOLD and RUN so `swData` is valid when the core leaves reset.

## Timing
- Switch path: if first synchroniser flop captures new level at edge k and the level holds, `swData` updates at edge k+DEBOUNCE_CYCLES+1; `swChanged` high from that edge for one cycle.
- Pulses shorter than DEBOUNCE_CYCLES synchronised cycles never reach `swData`.
- `cpuRstOut` falls on the RST_STRETCH-th rising edge after `reset` deasserts.
- `cpuOut` latency: 1 edge from `cpuWrEn` sample.
- `reset` asserted mid-count/mid-debounce: all outputs take reset values asynchronously, no clock needed; partial counts discarded.

## Configuration
- `AEOLUS_IO_EDGE_EN` defined: adds ports `swEdge` out SW_WIDTH (sticky rising-edge flags) and `swEdgeClr` in 1. A bit sets when its `swData` bit goes 0->1; `swEdgeClr`=1 clears all bits at the edge; set and clear on same edge -> set wins. Reset value 0.
- Not defined: ports and logic absent; all other behaviour identical.

## Test plan
- Reset release: `reset`=1, `switches`=8'hFF -> `cpuOut`=0, `swData`=0, `cpuRstOut`=1 with no clock; drop `reset` -> `cpuRstOut` falls on 8th edge; `swData`=8'hFF at k+17 with one `swChanged` pulse.
- Debounce accept: `switches` 8'h00 -> 8'hA5 held -> `swData`=8'hA5 exactly DEBOUNCE_CYCLES+1 edges after first capture, single `swChanged` pulse.
- Glitch reject: bit0 high for 10 cycles then low -> `swData` stays 8'h00, `swChanged` never asserts.
- Write gating: `cpuWrEn`=1, data 4'h3 during HOLD -> `cpuOut` stays 4'h0; in RUN data 4'h9 -> `cpuOut`=4'h9 after one edge, holds when `cpuWrEn`=0.
- Async reset mid-operation: assert `reset` between edges with counters mid-count and `cpuOut`=4'h9 -> all outputs to reset values immediately; after release, full stretch and debounce restart from zero.
- With `AEOLUS_IO_EDGE_EN`: `swData` bit3 rises on same edge as `swEdgeClr`=1 -> `swEdge`=8'h08; next `swEdgeClr` alone -> 8'h00.

Source files
------------

// File: rtl/aeolus_io_port.sv
// Board I/O front-end: switch synchronise/debounce, CPU output port, stretched core reset.
// Optional build macro AEOLUS_IO_EDGE_EN adds sticky rising-edge flags (swEdge/swEdgeClr).
module aeolus_io_port #(
  parameter int unsigned SW_WIDTH        = 8,
  parameter int unsigned OUT_WIDTH       = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned RST_STRETCH     = 8
) (
  input  logic                 boardCLK,
  input  logic                 reset,
  input  logic [SW_WIDTH-1:0]  switches,
  output logic [SW_WIDTH-1:0]  swData,
  output logic                 swChanged,
  input  logic                 cpuWrEn,
  input  logic [OUT_WIDTH-1:0] cpuWrData,
  output logic [OUT_WIDTH-1:0] cpuOut,
  output logic                 cpuRstOut
`ifdef AEOLUS_IO_EDGE_EN
  ,
  output logic [SW_WIDTH-1:0]  swEdge,
  input  logic                 swEdgeClr
`endif
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned STR_W = $clog2(RST_STRETCH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [STR_W-1:0] STR_LAST = STR_W'(RST_STRETCH - 1);

  typedef enum logic {HOLD, RUN} rst_state_t;

  logic [SW_WIDTH-1:0] sync1;
  logic [SW_WIDTH-1:0] sync2;
  logic [CNT_W-1:0]    cnt     [SW_WIDTH];
  logic [CNT_W-1:0]    cnt_nxt [SW_WIDTH];
  logic [SW_WIDTH-1:0] upd;
  rst_state_t          state;
  logic [STR_W-1:0]    str_cnt;

  // Per-bit debounce: a bit is accepted only after DEBOUNCE_CYCLES consecutive differing samples
  always_comb begin
    for (int i = 0; i < int'(SW_WIDTH); i++) begin
      cnt_nxt[i] = '0;
      upd[i]     = 1'b0;
      if (sync2[i] != swData[i]) begin
        if (cnt[i] == CNT_LAST) upd[i] = 1'b1;
        else                    cnt_nxt[i] = cnt[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge boardCLK or posedge reset) begin
    if (reset) begin
      sync1     <= '0;
      sync2     <= '0;
      swData    <= '0;
      swChanged <= 1'b0;
      for (int i = 0; i < int'(SW_WIDTH); i++) cnt[i] <= '0;
    end else begin
      sync1     <= switches;
      sync2     <= sync1;
      swData    <= (swData & ~upd) | (sync2 & upd);
      swChanged <= |upd;
      for (int i = 0; i < int'(SW_WIDTH); i++) cnt[i] <= cnt_nxt[i];
    end
  end

  // Reset stretcher; the output port only accepts writes once the core is running
  always_ff @(posedge boardCLK or posedge reset) begin
    if (reset) begin
      state     <= HOLD;
      str_cnt   <= '0;
      cpuRstOut <= 1'b1;
      cpuOut    <= '0;
    end else if (state == HOLD) begin
      if (str_cnt == STR_LAST) begin
        state     <= RUN;
        str_cnt   <= '0;
        cpuRstOut <= 1'b0;
      end else begin
        str_cnt <= str_cnt + STR_W'(1);
      end
    end else if (cpuWrEn) begin
      cpuOut <= cpuWrData;
    end
  end

`ifdef AEOLUS_IO_EDGE_EN
  // Sticky rise flags; a new rise beats a simultaneous clear
  always_ff @(posedge boardCLK or posedge reset) begin
    if (reset) swEdge <= '0;
    else       swEdge <= (swEdgeClr ? '0 : swEdge) | (upd & sync2);
  end
`endif

endmodule

// File: tb/tb_aeolus_io_port.sv
// Self-checking bench for aeolus_io_port: directed scenarios plus randomized traffic
// against a sample-window reference model. Define AEOLUS_IO_EDGE_EN to cover swEdge.
module tb_aeolus_io_port;
  localparam int SW_W = 8;
  localparam int OUT_W = 4;
  localparam int DEB = 16;
  localparam int STR = 8;

  logic             boardCLK = 1'b0;
  logic             reset;
  logic [SW_W-1:0]  switches;
  logic [SW_W-1:0]  swData;
  logic             swChanged;
  logic             cpuWrEn;
  logic [OUT_W-1:0] cpuWrData;
  logic [OUT_W-1:0] cpuOut;
  logic             cpuRstOut;
`ifdef AEOLUS_IO_EDGE_EN
  logic [SW_W-1:0]  swEdge;
  logic             swEdgeClr;
`endif

  aeolus_io_port #(
    .SW_WIDTH(SW_W), .OUT_WIDTH(OUT_W), .DEBOUNCE_CYCLES(DEB), .RST_STRETCH(STR)
  ) dut (
    .boardCLK(boardCLK),
    .reset(reset),
    .switches(switches),
    .swData(swData),
    .swChanged(swChanged),
    .cpuWrEn(cpuWrEn),
    .cpuWrData(cpuWrData),
    .cpuOut(cpuOut),
    .cpuRstOut(cpuRstOut)
`ifdef AEOLUS_IO_EDGE_EN
    ,
    .swEdge(swEdge),
    .swEdgeClr(swEdgeClr)
`endif
  );

  always #5 boardCLK = ~boardCLK;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: raw samples per edge, debounced value, edges since reset release
  logic [SW_W-1:0]  hist[$];
  logic [SW_W-1:0]  m_sw;
  logic             m_chg;
  logic [OUT_W-1:0] m_out;
  logic             m_rst;
  logic [SW_W-1:0]  m_edge;
  int               edge_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < DEB + 2; i++) hist.push_back('0);
    m_sw = '0; m_chg = 1'b0; m_out = '0; m_rst = 1'b1; m_edge = '0; edge_cnt = 0;
  endtask

  task automatic check_all(input string pfx);
    check_eq({pfx, "swData"}, 32'(swData), 32'(m_sw));
    check_eq({pfx, "swChanged"}, 32'(swChanged), 32'(m_chg));
    check_eq({pfx, "cpuOut"}, 32'(cpuOut), 32'(m_out));
    check_eq({pfx, "cpuRstOut"}, 32'(cpuRstOut), 32'(m_rst));
`ifdef AEOLUS_IO_EDGE_EN
    check_eq({pfx, "swEdge"}, 32'(swEdge), 32'(m_edge));
`endif
  endtask

  // One clock edge: advance the model from the inputs presented before the edge, then compare
  task automatic tick();
    logic [SW_W-1:0]  smp;
    logic [SW_W-1:0]  flip;
    logic             we;
    logic [OUT_W-1:0] wd;
    logic             clr;
    logic             all_diff;
    smp = switches; we = cpuWrEn; wd = cpuWrData; clr = 1'b0;
`ifdef AEOLUS_IO_EDGE_EN
    clr = swEdgeClr;
`endif
    @(posedge boardCLK);
    edge_cnt++;
    hist.push_back(smp);
    while (hist.size() > DEB + 2) void'(hist.pop_front());
    // A bit flips when all DEB samples ending two edges ago disagree with it
    for (int b = 0; b < SW_W; b++) begin
      all_diff = 1'b1;
      for (int j = 0; j < DEB; j++) if (hist[j][b] == m_sw[b]) all_diff = 1'b0;
      flip[b] = all_diff;
    end
    m_edge = (clr ? '0 : m_edge) | (flip & ~m_sw);
    m_chg  = |flip;
    m_sw   = m_sw ^ flip;
    if (edge_cnt - 1 >= STR && we) m_out = wd;
    m_rst = (edge_cnt < STR);
    #1;
    check_all("");
  endtask

  // Assert reset between edges and check outputs before any clock edge arrives
  task automatic do_reset(input int hold);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all("async_rst_");
    repeat (hold) @(posedge boardCLK);
    #2 reset = 1'b0;
  endtask

  int fall_edge;
  int chg_edge;
  int pulses;
  int len;

  task automatic run_measure(input int n);
    fall_edge = -1; chg_edge = -1; pulses = 0;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (cpuRstOut == 1'b0 && fall_edge < 0) fall_edge = i;
      if (swChanged) begin
        pulses++;
        if (chg_edge < 0) chg_edge = i;
      end
      if (i == STR - 1) check_eq("hold_gate_cpuOut", 32'(cpuOut), 32'h0);
    end
  endtask

  initial begin
    reset = 1'b1; switches = 8'hFF; cpuWrEn = 1'b1; cpuWrData = 4'h3;
`ifdef AEOLUS_IO_EDGE_EN
    swEdgeClr = 1'b0;
`endif
    model_reset();
    #3;
    check_all("init_");
    repeat (2) @(posedge boardCLK);
    #2 reset = 1'b0;

    // Reset release: stretch of STR edges, FF accepted DEB+2 edges after release
    run_measure(STR - 1);
    cpuWrEn = 1'b0;
    for (int i = STR; i <= 30; i++) begin
      tick();
      if (cpuRstOut == 1'b0 && fall_edge < 0) fall_edge = i;
      if (swChanged) begin
        pulses++;
        if (chg_edge < 0) chg_edge = i;
      end
    end
    check_eq("rst_fall_edge", 32'(fall_edge), 32'(STR));
    check_eq("ff_accept_edge", 32'(chg_edge), 32'(DEB + 2));
    check_eq("ff_pulses", 32'(pulses), 32'd1);
    check_eq("ff_value", 32'(swData), 32'hFF);

    // Debounce accept of A5 from 00
    switches = 8'h00;
    repeat (20) tick();
    switches = 8'hA5;
    pulses = 0; chg_edge = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (swChanged) begin
        pulses++;
        if (chg_edge < 0) chg_edge = i;
      end
    end
    check_eq("a5_latency", 32'(chg_edge - 1), 32'(DEB + 1));
    check_eq("a5_pulses", 32'(pulses), 32'd1);
    check_eq("a5_value", 32'(swData), 32'hA5);

    // Glitch reject on bit0
    switches = 8'h00;
    repeat (20) tick();
    pulses = 0;
    switches = 8'h01;
    for (int i = 0; i < 10; i++) begin tick(); if (swChanged) pulses++; end
    switches = 8'h00;
    for (int i = 0; i < 30; i++) begin tick(); if (swChanged) pulses++; end
    check_eq("glitch_pulses", 32'(pulses), 32'd0);
    check_eq("glitch_value", 32'(swData), 32'h00);

    // Write in RUN, then hold
    cpuWrEn = 1'b1; cpuWrData = 4'h9;
    tick();
    check_eq("wr_run", 32'(cpuOut), 32'h9);
    cpuWrEn = 1'b0; cpuWrData = 4'h6;
    repeat (3) tick();
    check_eq("wr_hold", 32'(cpuOut), 32'h9);

    // Async reset mid-debounce with cpuOut loaded, then full restart
    switches = 8'h3C;
    repeat (5) tick();
    do_reset(1);
    run_measure(30);
    check_eq("rerst_fall_edge", 32'(fall_edge), 32'(STR));
    check_eq("rerst_accept_edge", 32'(chg_edge), 32'(DEB + 2));
    check_eq("rerst_value", 32'(swData), 32'h3C);

`ifdef AEOLUS_IO_EDGE_EN
    // Rise on bit3 coinciding with a clear: set wins
    switches = 8'h00;
    repeat (20) tick();
    swEdgeClr = 1'b1; tick(); swEdgeClr = 1'b0;
    switches = 8'h08;
    repeat (DEB + 1) tick();
    swEdgeClr = 1'b1; tick();
    check_eq("edge_set_wins", 32'(swEdge), 32'h08);
    swEdgeClr = 1'b0; tick();
    swEdgeClr = 1'b1; tick(); swEdgeClr = 1'b0;
    check_eq("edge_clear", 32'(swEdge), 32'h00);
`endif

    // Randomized traffic with occasional mid-operation resets
    for (int n = 0; n < 80; n++) begin
      switches = 8'($urandom);
      len = $urandom_range(1, 26);
      for (int i = 0; i < len; i++) begin
        cpuWrEn = 1'($urandom);
        cpuWrData = 4'($urandom);
`ifdef AEOLUS_IO_EDGE_EN
        swEdgeClr = ($urandom_range(0, 7) == 0);
`endif
        tick();
      end
      if ($urandom_range(0, 15) == 0) do_reset($urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
